// File: rtl/key_command_scheduler.sv
// Turns level-held PS/2 key flags into game commands: edge actions, direction
// auto-repeat, fire cooldown, fixed-priority valid/ready output, paused flag.
module key_command_scheduler #(
  parameter int INIT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int FIRE_COOLDOWN = 10000000,
  parameter int CNT_W         = 25
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       up_key,
  input  logic       down_key,
  input  logic       left_key,
  input  logic       right_key,
  input  logic       ctrl_key,
  input  logic       end_key,
  input  logic       home_key,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       paused
);

  typedef enum logic [1:0] {
    D_IDLE   = 2'd0,
    D_DELAY  = 2'd1,
    D_REPEAT = 2'd2
  } dir_state_t;

  localparam logic [2:0]       CMD_FIRE    = 3'd5;
  localparam logic [2:0]       CMD_PAUSE   = 3'd6;
  localparam logic [2:0]       CMD_RESTART = 3'd7;
  localparam logic [CNT_W-1:0] INIT_LOAD   = CNT_W'(INIT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LOAD    = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(FIRE_COOLDOWN);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

  logic [6:0]       w_keys;
  logic [3:0]       w_dir_keys;
  logic [6:0]       w_rise;
  logic [6:0]       r_key_q;
  dir_state_t       r_dstate;
  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cool;
  logic             r_dir_pend;
  logic [1:0]       r_dir_code;
  logic             r_fire_pend;
  logic             r_pause_pend;
  logic             r_rst_pend;
  logic             r_valid;
  logic [2:0]       r_code;
  logic             r_paused;
  logic             w_sel_held;
  logic             w_dir_any;
  logic [1:0]       w_prio_sel;
  logic             w_fire_set;
  logic             w_slot_free;
  logic             w_accept;
  logic             w_any_pend;
  logic [2:0]       w_pick_code;
  logic             w_take_rst;
  logic             w_take_pause;
  logic             w_take_fire;
  logic             w_take_dir;

  assign w_keys      = {home_key, end_key, ctrl_key, right_key, left_key, down_key, up_key};
  assign w_dir_keys  = w_keys[3:0];
  assign w_rise      = w_keys & ~r_key_q;
  assign w_dir_any   = |w_dir_keys;
  assign w_sel_held  = w_dir_keys[r_sel];
  assign w_fire_set  = w_rise[4] & ~r_paused & (r_cool == CNT_ZERO);
  assign w_slot_free = ~r_valid | cmd_ready;
  assign w_accept    = r_valid & cmd_ready;
  assign w_any_pend  = r_rst_pend | r_pause_pend | r_fire_pend | r_dir_pend;

  assign cmd_valid = r_valid;
  assign cmd_code  = r_code;
  assign paused    = r_paused;

  // Fixed direction priority UP > DOWN > LEFT > RIGHT
  always_comb begin
    if (up_key) begin
      w_prio_sel = 2'd0;
    end else if (down_key) begin
      w_prio_sel = 2'd1;
    end else if (left_key) begin
      w_prio_sel = 2'd2;
    end else begin
      w_prio_sel = 2'd3;
    end
  end

  // Output arbiter: RESTART > PAUSE > FIRE > direction; a flag is only taken when the slot is free
  always_comb begin
    w_pick_code  = 3'd0;
    w_take_rst   = 1'b0;
    w_take_pause = 1'b0;
    w_take_fire  = 1'b0;
    w_take_dir   = 1'b0;
    if (r_rst_pend) begin
      w_pick_code = CMD_RESTART;
      w_take_rst  = w_slot_free;
    end else if (r_pause_pend) begin
      w_pick_code  = CMD_PAUSE;
      w_take_pause = w_slot_free;
    end else if (r_fire_pend) begin
      w_pick_code = CMD_FIRE;
      w_take_fire = w_slot_free;
    end else if (r_dir_pend) begin
      w_pick_code = {1'b0, r_dir_code} + 3'd1;
      w_take_dir  = w_slot_free;
    end else begin
      w_pick_code = 3'd0;
    end
  end

  // Key history for rising-edge detection
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_key_q <= 7'd0;
    end else begin
      r_key_q <= w_keys;
    end
  end

  // Direction FSM and direction pending flag; a fresh set overrides the arbiter's clear
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_dstate   <= D_IDLE;
      r_sel      <= 2'd0;
      r_cnt      <= CNT_ZERO;
      r_dir_pend <= 1'b0;
      r_dir_code <= 2'd0;
    end else begin
      if (w_take_dir) begin
        r_dir_pend <= 1'b0;
      end
      case (r_dstate)
        D_IDLE: begin
          if (w_dir_any && !r_paused) begin
            r_sel      <= w_prio_sel;
            r_dir_pend <= 1'b1;
            r_dir_code <= w_prio_sel;
            r_cnt      <= INIT_LOAD;
            r_dstate   <= D_DELAY;
          end
        end
        D_DELAY, D_REPEAT: begin
          if (!w_sel_held || r_paused) begin
            r_dstate <= D_IDLE;
          end else if (r_cnt == CNT_ZERO) begin
            r_dir_pend <= 1'b1;
            r_dir_code <= r_sel;
            r_cnt      <= REP_LOAD;
            r_dstate   <= D_REPEAT;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: r_dstate <= D_IDLE;
      endcase
    end
  end

  // Edge-triggered pending flags and the free-running fire cooldown
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_rst_pend   <= 1'b0;
      r_pause_pend <= 1'b0;
      r_fire_pend  <= 1'b0;
      r_cool       <= CNT_ZERO;
    end else begin
      r_rst_pend   <= (r_rst_pend & ~w_take_rst) | w_rise[6];
      r_pause_pend <= (r_pause_pend & ~w_take_pause) | w_rise[5];
      r_fire_pend  <= (r_fire_pend & ~w_take_fire) | w_fire_set;
      if (w_fire_set) begin
        r_cool <= COOL_LOAD;
      end else if (r_cool != CNT_ZERO) begin
        r_cool <= r_cool - CNT_ONE;
      end
    end
  end

  // Output slot and paused flag; cmd_code keeps its last value when the slot empties
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_valid  <= 1'b0;
      r_code   <= 3'd0;
      r_paused <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_code == CMD_PAUSE) begin
          r_paused <= ~r_paused;
        end else if (r_code == CMD_RESTART) begin
          r_paused <= 1'b0;
        end
      end
      if (w_slot_free) begin
        if (w_any_pend) begin
          r_valid <= 1'b1;
          r_code  <= w_pick_code;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_command_scheduler.sv
// Scoreboard bench for key_command_scheduler: directed scenarios plus random
// key/ready/reset traffic checked against a time-based reference model.
module tb_key_command_scheduler;

  localparam int INIT_DELAY    = 4;
  localparam int REPEAT_PERIOD = 2;
  localparam int FIRE_COOLDOWN = 3;
  localparam int CNT_W         = 8;

  localparam logic [6:0] K_NONE  = 7'b0000000;
  localparam logic [6:0] K_UP    = 7'b0000001;
  localparam logic [6:0] K_LEFT  = 7'b0000100;
  localparam logic [6:0] K_CTRL  = 7'b0010000;
  localparam logic [6:0] K_END   = 7'b0100000;
  localparam logic [6:0] K_HOME  = 7'b1000000;

  typedef struct packed {
    logic       v;
    logic [2:0] c;
    logic       p;
  } st_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [6:0] keys;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       paused;

  st_t        exp_state[$];
  logic [2:0] exp_codes[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  bit         do_final = 1'b0;

  // reference model state
  int         m_cyc = 0;
  int         m_last_fire = -1000;
  int         m_age = 0;
  int         m_sel = 0;
  bit         m_active = 1'b0;
  bit         m_rst = 1'b0, m_pause = 1'b0, m_fire = 1'b0, m_dir = 1'b0;
  bit         m_valid = 1'b0, m_paused = 1'b0;
  logic [1:0] m_dir_code = 2'd0;
  logic [2:0] m_code = 3'd0;
  logic [6:0] m_prev = 7'd0;

  always #5 clk = ~clk;

  key_command_scheduler #(
    .INIT_DELAY   (INIT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .FIRE_COOLDOWN(FIRE_COOLDOWN),
    .CNT_W        (CNT_W)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .up_key   (keys[0]),
    .down_key (keys[1]),
    .left_key (keys[2]),
    .right_key(keys[3]),
    .ctrl_key (keys[4]),
    .end_key  (keys[5]),
    .home_key (keys[6]),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .paused   (paused)
  );

  // Predicts the effect of the coming clock edge. Direction repeats follow from how
  // long the selected key has been held; fire acceptance from time since the last fire.
  task automatic model_step(input logic [6:0] k, input logic rdy, input logic rn);
    logic [6:0] rise;
    bit dset, fset, free, accept;
    int dsel, pick;
    st_t s;
    if (!rn) begin
      m_rst = 1'b0; m_pause = 1'b0; m_fire = 1'b0; m_dir = 1'b0; m_dir_code = 2'd0;
      m_valid = 1'b0; m_code = 3'd0; m_paused = 1'b0; m_prev = 7'd0; m_active = 1'b0;
      m_last_fire = m_cyc - 1000;
      exp_codes.delete();
    end else begin
      rise   = k & ~m_prev;
      free   = !m_valid || rdy;
      accept = m_valid && rdy;
      dset = 1'b0;
      dsel = 0;
      if (m_active) begin
        if (!k[m_sel] || m_paused) begin
          m_active = 1'b0;
        end else begin
          m_age++;
          if (m_age == INIT_DELAY ||
              (m_age > INIT_DELAY && (m_age - INIT_DELAY) % REPEAT_PERIOD == 0)) begin
            dset = 1'b1;
            dsel = m_sel;
          end
        end
      end else if (k[3:0] != 4'd0 && !m_paused) begin
        m_sel    = k[0] ? 0 : k[1] ? 1 : k[2] ? 2 : 3;
        m_active = 1'b1;
        m_age    = 0;
        dset     = 1'b1;
        dsel     = m_sel;
      end
      fset = rise[4] && !m_paused && (m_cyc - m_last_fire > FIRE_COOLDOWN);
      if (fset) m_last_fire = m_cyc;
      if (accept) begin
        if (m_code == 3'd6) m_paused = !m_paused;
        else if (m_code == 3'd7) m_paused = 1'b0;
      end
      if (free) begin
        pick = 0;
        if (m_rst) begin pick = 7; m_rst = 1'b0; end
        else if (m_pause) begin pick = 6; m_pause = 1'b0; end
        else if (m_fire) begin pick = 5; m_fire = 1'b0; end
        else if (m_dir) begin pick = int'(m_dir_code) + 1; m_dir = 1'b0; end
        if (pick != 0) begin
          m_valid = 1'b1;
          m_code  = pick[2:0];
          exp_codes.push_back(pick[2:0]);
        end else begin
          m_valid = 1'b0;
        end
      end
      if (rise[6]) m_rst = 1'b1;
      if (rise[5]) m_pause = 1'b1;
      if (fset) m_fire = 1'b1;
      if (dset) begin
        m_dir      = 1'b1;
        m_dir_code = dsel[1:0];
      end
      m_prev = k;
    end
    m_cyc++;
    s.v = m_valid;
    s.c = m_code;
    s.p = m_paused;
    exp_state.push_back(s);
  endtask

  task automatic tick(input logic [6:0] k, input logic rdy, input logic rn);
    keys      = k;
    cmd_ready = rdy;
    resetn    = rn;
    model_step(k, rdy, rn);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] k, input logic rdy, input int n);
    for (int i = 0; i < n; i++) tick(k, rdy, 1'b1);
  endtask

  // Monitor: per-cycle output state plus the accepted-command scoreboard
  initial begin
    st_t s;
    logic [2:0] c;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if (exp_state.size() == 0) begin
          errors++;
          $display("FAIL state: no expected record at %0t", $time);
        end else begin
          s = exp_state.pop_front();
          if (cmd_valid !== s.v || cmd_code !== s.c || paused !== s.p) begin
            errors++;
            $display("FAIL state at %0t: got valid=%0b code=%0d paused=%0b, expected valid=%0b code=%0d paused=%0b",
                     $time, cmd_valid, cmd_code, paused, s.v, s.c, s.p);
          end
        end
        if (resetn === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
          checks++;
          if (exp_codes.size() == 0) begin
            errors++;
            $display("FAIL cmd at %0t: got code %0d, expected no command", $time, cmd_code);
          end else begin
            c = exp_codes.pop_front();
            if (cmd_code !== c) begin
              errors++;
              $display("FAIL cmd at %0t: got code %0d, expected %0d", $time, cmd_code, c);
            end
          end
        end
        if (do_final) begin
          checks++;
          if (exp_codes.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d commands never issued, expected 0", exp_codes.size());
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios, random traffic, then a drain
  initial begin
    logic [6:0] rk;
    keys      = K_NONE;
    cmd_ready = 1'b1;
    resetn    = 1'b0;
    tick(K_NONE, 1'b1, 1'b0);
    mon_en = 1'b1;
    tick(K_NONE, 1'b1, 1'b0);
    hold(K_NONE, 1'b1, 2);

    // held UP: initial issue then auto-repeat, release stops it
    hold(K_UP, 1'b1, 11);
    hold(K_NONE, 1'b1, 4);
    // UP+LEFT together, then drop UP
    hold(K_UP | K_LEFT, 1'b1, 3);
    hold(K_LEFT, 1'b1, 4);
    hold(K_NONE, 1'b1, 2);
    // ctrl rises inside and after the cooldown
    tick(K_CTRL, 1'b1, 1'b1);
    tick(K_NONE, 1'b1, 1'b1);
    tick(K_CTRL, 1'b1, 1'b1);
    tick(K_NONE, 1'b1, 1'b1);
    tick(K_CTRL, 1'b1, 1'b1);
    hold(K_NONE, 1'b1, 3);
    // home, end, ctrl in one cycle, then unpause
    tick(K_HOME | K_END | K_CTRL, 1'b1, 1'b1);
    hold(K_NONE, 1'b1, 5);
    tick(K_END, 1'b1, 1'b1);
    hold(K_NONE, 1'b1, 3);
    // back-pressure with UP held and END pressed
    hold(K_UP, 1'b0, 3);
    tick(K_UP | K_END, 1'b0, 1'b1);
    hold(K_UP, 1'b0, 3);
    hold(K_UP, 1'b1, 6);
    hold(K_NONE, 1'b1, 3);
    tick(K_END, 1'b1, 1'b1);
    hold(K_NONE, 1'b1, 3);
    // reset mid-repeat with FIRE pending
    hold(K_UP, 1'b1, 7);
    tick(K_UP | K_CTRL, 1'b0, 1'b1);
    tick(K_UP, 1'b0, 1'b1);
    tick(K_UP, 1'b1, 1'b0);
    hold(K_UP, 1'b1, 4);
    hold(K_NONE, 1'b1, 2);

    // random traffic
    rk = K_NONE;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 7; b++) begin
        if ($urandom_range(0, 7) == 0) rk[b] = ~rk[b];
      end
      tick(rk, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));
    end

    hold(K_NONE, 1'b1, 12);
    do_final = 1'b1;
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
